// File: rtl/day_of_month.sv
// day_of_month: calendar day counter with carry to the month stage and +/- edit; LEAP_YEAR_EN enables Feb 29
module day_of_month #(
  parameter logic [4:0]  MODIFY_STATE = 5'd4,
  parameter logic [14:0] RESET_DAY    = 15'd1
) (
  input  logic        i_clk_0_001s,
  input  logic        i_reset,
  input  logic [4:0]  state,
  input  logic        is_modify,
  input  logic        i_plus,
  input  logic        i_minus,
  input  logic        i_enable,
  input  logic [14:0] i_month,
  input  logic [14:0] i_year,
  output logic        o_enable,
  output logic [14:0] o_day
);
  logic r_enable, r_plus, r_minus;
  logic enable_fall, plus_fall, minus_fall;
  logic leap, edit;
  logic [14:0] dim;
`ifdef LEAP_YEAR_EN
  assign leap = (i_year[1:0] == 2'd0) && ((i_year % 15'd100 != 15'd0) || (i_year % 15'd400 == 15'd0));
`else
  logic unused_year;
  assign unused_year = ^i_year;
  assign leap = 1'b0;
`endif
  assign edit = is_modify && (state == MODIFY_STATE);
  always_comb
    dim = (i_month == 15'd2) ? (leap ? 15'd29 : 15'd28) :
          (i_month == 15'd4 || i_month == 15'd6 || i_month == 15'd9 || i_month == 15'd11) ? 15'd30 : 15'd31;
  always_ff @(posedge i_clk_0_001s) begin
    if (i_reset) begin
      {r_enable, r_plus, r_minus}          <= '0;
      {enable_fall, plus_fall, minus_fall} <= '0;
      o_enable <= 1'b0;
      o_day    <= RESET_DAY;
    end else begin
      {r_enable, r_plus, r_minus} <= {i_enable, i_plus, i_minus};
      enable_fall <= r_enable & ~i_enable;
      plus_fall   <= r_plus   & ~i_plus;
      minus_fall  <= r_minus  & ~i_minus;
      o_enable    <= enable_fall && (o_day >= dim);
      // a stale day beyond the month length rolls over like a normal month end
      if (enable_fall)
        o_day <= (o_day >= dim) ? 15'd1 : o_day + 15'd1;
      else if (minus_fall && edit)
        o_day <= (o_day == 15'd1) ? dim : o_day - 15'd1;
      else if (plus_fall && edit)
        o_day <= (o_day >= dim) ? 15'd1 : o_day + 15'd1;
      else if (o_day > dim)
        o_day <= dim;
    end
  end
endmodule

// File: tb/tb_day_of_month.sv
// tb_day_of_month: vector table, corner sequences and random run against a calendar reference model
module tb_day_of_month;
  logic        clk = 1'b0;
  logic        rst, is_modify, plus, minus, en;
  logic [4:0]  state;
  logic [14:0] month, year;
  logic        o_enable;
  logic [14:0] o_day;
  int passed = 0, total = 0;
  int m_day = 0;
  bit m_en = 0;
  bit h1e, h1p, h1m, h2e, h2p, h2m;
  bit r1 = 1, r2 = 1;
`ifdef LEAP_YEAR_EN
  localparam bit LEAP = 1'b1;
`else
  localparam bit LEAP = 1'b0;
`endif

  day_of_month dut (
    .i_clk_0_001s(clk), .i_reset(rst), .state(state), .is_modify(is_modify),
    .i_plus(plus), .i_minus(minus), .i_enable(en), .i_month(month), .i_year(year),
    .o_enable(o_enable), .o_day(o_day)
  );

  always #5 clk = ~clk;

  function automatic int days_in(int m, int y);
    int len[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    bit lp = LEAP && (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
    if (m < 1 || m > 12) return 31;
    return len[m-1] + ((m == 2 && lp) ? 1 : 0);
  endfunction

  // a button/carry event acts two edges after its falling sample unless a reset intervened
  task automatic model_edge();
    bit ef = h2e && !h1e && !r1 && !r2;
    bit pf = h2p && !h1p && !r1 && !r2;
    bit mf = h2m && !h1m && !r1 && !r2;
    bit ed = is_modify && (state == 5'd4);
    int d = days_in(int'(month), int'(year));
    m_en = 0;
    if (rst) m_day = 1;
    else if (ef) begin
      if (m_day >= d) begin m_day = 1; m_en = 1; end
      else m_day++;
    end
    else if (mf && ed) m_day = (m_day == 1) ? d : m_day - 1;
    else if (pf && ed) m_day = (m_day >= d) ? 1 : m_day + 1;
    else if (m_day > d) m_day = d;
    {h2e, h2p, h2m} = {h1e, h1p, h1m};
    {h1e, h1p, h1m} = {en, plus, minus};
    r2 = r1;
    r1 = rst;
  endtask

  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_day", int'(o_day), m_day);
    chk("model_carry", int'(o_enable), int'(m_en));
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic preset_day(int d);
    month = 15'd1; is_modify = 1; state = 5'd4;
    for (int i = 1; i < d; i++) begin
      plus = 1; tick(); plus = 0; tick();
    end
    tick(); tick();
  endtask

  typedef struct {
    int month; int year; int preset; int op; int md; int st; int exp_day; int exp_carry;
  } vec_t;
  vec_t vec[16];

  initial begin
    int carries;
    rst = 1; is_modify = 0; plus = 0; minus = 0; en = 0; state = 0; month = 1; year = 15'd2023;
    tick(); tick();
    rst = 0;
    do_reset();
    chk("reset_day", int'(o_day), 1);
    chk("reset_carry", int'(o_enable), 0);

    vec[0]  = '{4, 2023, 30, 0, 1, 4, 1, 1};
    vec[1]  = '{4, 2023, 29, 0, 1, 4, 30, 0};
    vec[2]  = '{1, 2023, 31, 0, 0, 0, 1, 1};
    vec[3]  = '{2, 2023, 28, 0, 0, 0, 1, 1};
    vec[4]  = '{2, 2000, 28, 0, 0, 0, LEAP ? 29 : 1, LEAP ? 0 : 1};
    vec[5]  = '{2, 1900, 28, 0, 0, 0, 1, 1};
    vec[6]  = '{2, 2024, 28, 0, 0, 0, LEAP ? 29 : 1, LEAP ? 0 : 1};
    vec[7]  = '{1, 2023, 1, 2, 1, 4, 31, 0};
    vec[8]  = '{1, 2023, 31, 1, 1, 4, 1, 0};
    vec[9]  = '{6, 2023, 1, 2, 1, 4, 30, 0};
    vec[10] = '{13, 2023, 30, 0, 0, 0, 31, 0};
    vec[11] = '{0, 2023, 31, 0, 0, 0, 1, 1};
    vec[12] = '{2, 2000, 1, 2, 1, 4, LEAP ? 29 : 28, 0};
    vec[13] = '{9, 2023, 15, 1, 1, 4, 16, 0};
    vec[14] = '{1, 2023, 5, 1, 1, 3, 5, 0};
    vec[15] = '{1, 2023, 5, 2, 0, 4, 5, 0};

    for (int k = 0; k < 16; k++) begin
      do_reset();
      preset_day(vec[k].preset);
      month = 15'(vec[k].month); year = 15'(vec[k].year);
      is_modify = vec[k].md[0]; state = 5'(vec[k].st);
      tick();
      carries = 0;
      for (int c = 0; c < 5; c++) begin
        en    = (c == 0) && (vec[k].op == 0);
        plus  = (c == 0) && (vec[k].op == 1);
        minus = (c == 0) && (vec[k].op == 2);
        tick();
        carries += int'(o_enable);
      end
      chk($sformatf("vec%0d_day", k), int'(o_day), vec[k].exp_day);
      chk($sformatf("vec%0d_carries", k), carries, vec[k].exp_carry);
    end

    // clamp after month edit
    do_reset(); preset_day(31);
    month = 15'd2; year = 15'd2023; is_modify = 0;
    tick();
    chk("clamp_day", int'(o_day), 28);
    chk("clamp_carry", int'(o_enable), 0);

    // carry and plus fall together: button dropped
    do_reset(); preset_day(10);
    en = 1; plus = 1; tick();
    en = 0; plus = 0; tick(); tick(); tick(); tick();
    chk("prio_day", int'(o_day), 11);

    // reset arriving while a carry fall is pending
    do_reset(); preset_day(5);
    en = 1; tick(); en = 0; tick();
    rst = 1; tick();
    chk("rst_mid_day", int'(o_day), 1);
    chk("rst_mid_carry", int'(o_enable), 0);
    rst = 0; tick(); tick(); tick();
    chk("rst_mid_after", int'(o_day), 1);

    // random run against the model
    for (int n = 0; n < 4000; n++) begin
      en = $urandom_range(0, 1) == 1;
      plus = $urandom_range(0, 3) == 0;
      minus = $urandom_range(0, 3) == 0;
      is_modify = $urandom_range(0, 3) != 0;
      state = 5'($urandom_range(3, 5));
      rst = $urandom_range(0, 299) == 0;
      if ($urandom_range(0, 39) == 0) month = 15'($urandom_range(0, 14));
      if ($urandom_range(0, 99) == 0)
        case ($urandom_range(0, 4))
          0: year = 15'd1900;
          1: year = 15'd2000;
          2: year = 15'd2023;
          3: year = 15'd2024;
          default: year = 15'($urandom_range(0, 32767));
        endcase
      tick();
    end
    rst = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
